seq_addsub: RTL and testbench
=============================

# seq_addsub

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, carrying between chunks in a register. It is the sequential, width-generic successor to the single-bit full adder in the combinational library. It serves datapaths that trade latency for a narrow carry chain. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 2.
- CHUNK, 8: bits added per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails. NCH = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = a+b+cin; 1 = a−b−cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Datapath: the effective B operand is b XOR {WIDTH{sub}}. The initial carry is cin XOR sub.
- Per chunk i (LSB first): {c, s} = A[i] + B'[i] + carry_reg. s is written to sum[i*CHUNK +: CHUNK] and c to carry_reg.
- ovf = carry into MSB XOR carry out of MSB, evaluated on the final chunk only. cout = final carry_reg.
- The block captures a, b, cin and sub at acceptance. Input changes during BUSY have no effect.
- State machine:
  - IDLE: in_ready=1. in_valid=1 accepts the operands, clears the chunk counter, loads the carry, and moves to BUSY.
  - BUSY: one chunk per cycle. After the chunk with counter = NCH−1 the block moves to DONE.
  - DONE: out_valid=1. out_ready=1 moves to IDLE.
- In DONE, in_ready=0. The block cannot accept new operands in the same cycle a result is retired; a new accept happens no earlier than the following cycle.
- sum, cout and ovf hold stable from out_valid rising until the handshake completes. Afterwards they keep their last value until the next result overwrites them.
- Reset (asynchronous, at any time including mid-BUSY or DONE):
  - The block enters IDLE and discards any operation in flight.
  - Reset outputs: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - The chunk counter and carry_reg are cleared.

## Timing
- Accept occurs at the rising edge where in_valid & in_ready.
- BUSY lasts exactly NCH cycles.
- out_valid rises NCH cycles after the accept edge. With CHUNK=WIDTH the latency is 1.
- Minimum issue interval is NCH+2 cycles when out_ready is held high. The cycles are: 1 accept in IDLE, NCH BUSY, 1 DONE.
- No combinational path from in_valid or out_ready to any output, except in_ready, which decodes state only.
- Back-pressure is unbounded: DONE holds indefinitely while out_ready=0.
- The block does not depend on reset deassertion timing relative to clk beyond standard synchronous release, which the system reset synchroniser provides.

## Test plan
- Add carry wrap (WIDTH=8, CHUNK=4): a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0, out_valid 2 cycles after accept.
- Signed overflow (WIDTH=8, CHUNK=4): a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1.
- Subtract with borrow (WIDTH=8, CHUNK=2): a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0, latency 4.
- Subtract with signed overflow (WIDTH=8, CHUNK=8): a=0x80, b=0x01, cin=0, sub=1 -> sum=0x7F, cout=1, ovf=1, latency 1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b.
  - Required: sum, cout and ovf stay stable, in_ready stays 0, and no second accept occurs.
  - Raise out_ready; the next accept is possible one cycle later.
- Reset mid-operation (WIDTH=32, CHUNK=8): pulse rst_n low during the 2nd BUSY cycle.
  - Immediately: out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
  - The interrupted result never appears.
  - A subsequent a=0xFFFFFFFF, b=0x00000001 completes with sum=0x00000000, cout=1, ovf=0.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB first,
// with the carry held in a register between chunks and valid/ready on both sides.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_params
            $error("seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [CHUNK:0]   add;
    logic             last, c_msb;

    // Operands shift right each cycle so the active chunk is always the low CHUNK bits.
    assign add   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign c_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ add[CHUNK-1];
    assign last  = cnt_q == CW'(NCH - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = BUSY;
                cnt_d   = '0;
                carry_d = cin ^ sub;
                a_d     = a;
                b_d     = b ^ {WIDTH{sub}};
            end
            BUSY: begin
                cnt_d   = cnt_q + CW'(1);
                carry_d = add[CHUNK];
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = WIDTH'({add[CHUNK-1:0], acc_q} >> CHUNK);
                // Results publish only on the final chunk so sum never shows partial work.
                if (last) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = add[CHUNK];
                    ovf_d   = add[CHUNK] ^ c_msb;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: drives four configurations (32/8, 8/4, 8/2, 8/8) against an arithmetic
// reference model; directed corner cases, back-pressure, mid-operation reset, random ops.
module tb_seq_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  iv = '0;
    logic [31:0] a_bus = '0, b_bus = '0;
    logic        cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    wire  [3:0]  ov, ir, co, of;
    wire  [31:0] s0;
    wire  [7:0]  s1, s2, s3;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) d0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_bus), .b(b_bus), .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(s0), .cout(co[0]), .ovf(of[0]));
    seq_addsub #(.WIDTH(8), .CHUNK(4)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(s1), .cout(co[1]), .ovf(of[1]));
    seq_addsub #(.WIDTH(8), .CHUNK(2)) d2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .sum(s2), .cout(co[2]), .ovf(of[2]));
    seq_addsub #(.WIDTH(8), .CHUNK(8)) d3 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .sub(sub), .out_valid(ov[3]), .out_ready(out_ready),
        .sum(s3), .cout(co[3]), .ovf(of[3]));

    function automatic int width_of(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : (k == 2) ? 4 : 1;
    endfunction

    function automatic logic [33:0] obs(input int k);
        case (k)
            0:       return {of[0], co[0], s0};
            1:       return {of[1], co[1], 24'b0, s1};
            2:       return {of[2], co[2], 24'b0, s2};
            default: return {of[3], co[3], 24'b0, s3};
        endcase
    endfunction

    function automatic longint sx(input longint v, input int w);
        return v[w-1] ? v - (longint'(1) << w) : v;
    endfunction

    // Reference: {ovf, cout, sum} from plain integer arithmetic on unsigned and signed views.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, bv, input logic c, s);
        longint m  = (longint'(1) << w) - 1;
        longint ua = longint'(av) & m;
        longint ub = longint'(bv) & m;
        longint ci = c ? 1 : 0;
        longint sa = sx(ua, w);
        longint sb = sx(ub, w);
        longint r, sr;
        logic   cy, ofl;
        if (!s) begin
            r  = ua + ub + ci;
            cy = r > m;
            sr = sa + sb + ci;
        end else begin
            r  = ua - ub - ci;
            cy = ua >= ub + ci;
            sr = sa - sb - ci;
        end
        ofl = (sr > (m >> 1)) || (sr < -((m >> 1) + 1));
        return {ofl, cy, 32'(r & m)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic wait_out(input int k, output int n);
        n = 0;
        while (!ov[k] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic op(input int k, input logic [31:0] av, bv, input logic c, s, input int bp);
        logic [33:0] e;
        int          n;
        e = model(width_of(k), av, bv, c, s);
        @(negedge clk);
        chk($sformatf("in_ready_k%0d", k), ir[k], 1);
        a_bus = av; b_bus = bv; cin = c; sub = s; iv[k] = 1'b1;
        @(posedge clk);
        #1 iv[k] = 1'b0;
        a_bus = $urandom; b_bus = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        wait_out(k, n);
        chk($sformatf("latency_k%0d", k), n, lat_of(k));
        chk($sformatf("result_k%0d", k), obs(k), e);
        repeat (bp) begin
            @(posedge clk);
            #1 chk($sformatf("hold_k%0d", k), {ov[k], ir[k], obs(k)}, {1'b1, 1'b0, e});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk($sformatf("retire_k%0d", k), {ov[k], ir[k]}, 2'b01);
    endtask

    initial begin
        logic [33:0] e;
        logic [31:0] na, nb;
        int          n;
        logic        seen;
        #3;
        chk("reset_flags", {ov, ir}, {4'h0, 4'hF});
        chk("reset_d0", obs(0), 34'h0);
        chk("reset_d1", obs(1), 34'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(1, 32'hFF, 32'h01, 1'b0, 1'b0, 0);
        chk("wrap_exact", obs(1), {2'b01, 32'h00});
        op(1, 32'h7F, 32'h01, 1'b0, 1'b0, 0);
        chk("sovf_exact", obs(1), {2'b10, 32'h80});
        op(2, 32'h05, 32'h07, 1'b0, 1'b1, 0);
        chk("borrow_exact", obs(2), {2'b00, 32'hFE});
        op(3, 32'h80, 32'h01, 1'b0, 1'b1, 0);
        chk("subovf_exact", obs(3), {2'b11, 32'h7F});

        // Back-pressure on the 32-bit instance while inputs churn.
        e = model(32, 32'h89AB_CDEF, 32'h7654_3211, 1'b1, 1'b0);
        @(negedge clk);
        a_bus = 32'h89AB_CDEF; b_bus = 32'h7654_3211; cin = 1'b1; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        wait_out(0, n);
        chk("bp_latency", n, 4);
        repeat (5) begin
            @(negedge clk);
            iv[0] = ~iv[0]; a_bus = $urandom; b_bus = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk);
            #1 chk("bp_hold", {ov[0], ir[0], obs(0)}, {1'b1, 1'b0, e});
        end
        na = $urandom; nb = $urandom;
        @(negedge clk);
        out_ready = 1'b1; iv[0] = 1'b1; a_bus = na; b_bus = nb; cin = 1'b0; sub = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_retire_no_accept", {ov[0], ir[0], obs(0)}, {1'b0, 1'b1, e});
        @(posedge clk);
        #1 iv[0] = 1'b0;
        chk("bp_next_accept", ir[0], 0);
        wait_out(0, n);
        chk("bp_next_latency", n, 4);
        chk("bp_next_result", obs(0), model(32, na, nb, 1'b0, 1'b1));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Asynchronous reset during the second BUSY cycle.
        @(negedge clk);
        a_bus = 32'h1234_5678; b_bus = 32'h1111_1111; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_flags", {ov[0], ir[0]}, 2'b01);
        chk("rst_mid_out", obs(0), 34'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 seen = seen | ov[0];
        end
        chk("rst_no_ghost", seen, 0);
        op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        chk("rst_after_exact", obs(0), {2'b01, 32'h0});

        for (int i = 0; i < 40; i++)
            op(int'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
